// File: rtl/reorder_buffer.sv
// Reorder buffer: circular queue that retires completed instructions in program order.
// Optional query/forwarding port enabled by defining ROB_FWD_EN.
module reorder_buffer #(
    parameter int TAG_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             allocValid,
    input  logic [5:0]       allocType,
    input  logic [4:0]       allocDest,
    output logic             allocReady,
    output logic [TAG_W-1:0] allocTag,
    input  logic             cdbValid,
    input  logic [TAG_W-1:0] cdbTag,
    input  logic [31:0]      cdbData,
    input  logic             flush,
    output logic             ROBwriteEnable,
    output logic [31:0]      ROBwriteData,
    output logic [4:0]       ROBwriteIndex,
    output logic             memCommit,
    output logic [TAG_W:0]   count
`ifdef ROB_FWD_EN
    ,
    input  logic [TAG_W-1:0] qryTag,
    output logic             qryHit,
    output logic [31:0]      qryData
`endif
);

    localparam int DEPTH = 1 << TAG_W;
    localparam logic [TAG_W:0] FULL_CNT = {1'b1, {TAG_W{1'b0}}};

    localparam logic [5:0] OP_ADD  = 6'd0;
    localparam logic [5:0] OP_ADDI = 6'd1;
    localparam logic [5:0] OP_SUB  = 6'd2;
    localparam logic [5:0] OP_MUL  = 6'd3;
    localparam logic [5:0] OP_SLL  = 6'd4;
    localparam logic [5:0] OP_SRL  = 6'd5;
    localparam logic [5:0] OP_LW   = 6'd6;
    localparam logic [5:0] OP_SW   = 6'd7;
    localparam logic [5:0] OP_BNE  = 6'd8;
    localparam logic [5:0] OP_LI   = 6'd9;

    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] ready_q;
    logic [5:0]       type_q [DEPTH];
    logic [4:0]       dest_q [DEPTH];
    logic [31:0]      data_q [DEPTH];

    logic [TAG_W-1:0] head_q, tail_q;
    logic [TAG_W:0]   count_q, count_d;
    logic             we_q, mem_q;
    logic [31:0]      wdata_q;
    logic [4:0]       windex_q;

    logic       alloc_fire, commit_fire, cdb_hit;
    logic [5:0] head_type;
    logic       head_is_reg, head_is_sw;

    assign allocReady = (count_q != FULL_CNT);
    assign allocTag   = tail_q;
    assign alloc_fire = allocValid && allocReady;
    assign cdb_hit    = cdbValid && valid_q[cdbTag];
    assign head_type  = type_q[head_q];

    // Gating on the registered strobe forces a low cycle between register writes.
    assign commit_fire = valid_q[head_q] && ready_q[head_q] && !we_q;

    always_comb begin
        head_is_reg = 1'b0;
        case (head_type)
            OP_ADD, OP_ADDI, OP_SUB, OP_MUL,
            OP_SLL, OP_SRL, OP_LW, OP_LI: head_is_reg = 1'b1;
            default:                      head_is_reg = 1'b0;
        endcase
        head_is_sw = (head_type == OP_SW);
    end

    always_comb begin
        count_d = count_q;
        if (alloc_fire && !commit_fire)
            count_d = count_q + 1'b1;
        else if (!alloc_fire && commit_fire)
            count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q  <= '0;
            ready_q  <= '0;
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
            we_q     <= 1'b0;
            mem_q    <= 1'b0;
            wdata_q  <= '0;
            windex_q <= '0;
        end else if (flush) begin
            valid_q <= '0;
            ready_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            we_q    <= 1'b0;
            mem_q   <= 1'b0;
        end else begin
            if (alloc_fire) begin
                valid_q[tail_q] <= 1'b1;
                ready_q[tail_q] <= 1'b0;
                type_q[tail_q]  <= allocType;
                dest_q[tail_q]  <= allocDest;
                tail_q          <= tail_q + 1'b1;
            end
            if (cdb_hit)
                ready_q[cdbTag] <= 1'b1;
            // Retirement clears last so it wins over a CDB write to the same head slot.
            if (commit_fire) begin
                valid_q[head_q] <= 1'b0;
                ready_q[head_q] <= 1'b0;
                head_q          <= head_q + 1'b1;
                we_q            <= head_is_reg;
                mem_q           <= head_is_sw;
                if (head_is_reg) begin
                    wdata_q  <= data_q[head_q];
                    windex_q <= dest_q[head_q];
                end
            end else begin
                we_q  <= 1'b0;
                mem_q <= 1'b0;
            end
            count_q <= count_d;
        end
    end

    // Result payload needs no reset: it is only observed once its entry is ready.
    always_ff @(posedge clk) begin
        if (cdb_hit)
            data_q[cdbTag] <= cdbData;
    end

    assign ROBwriteEnable = we_q;
    assign ROBwriteData   = wdata_q;
    assign ROBwriteIndex  = windex_q;
    assign memCommit      = mem_q;
    assign count          = count_q;

`ifdef ROB_FWD_EN
    assign qryHit  = valid_q[qryTag] && ready_q[qryTag];
    assign qryData = data_q[qryTag];
`endif

endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer: queue-based reference model plus directed scenarios.
module tb_reorder_buffer;

    localparam int TAG_W = 3;
    localparam int DEPTH = 8;

    localparam logic [5:0] OP_ADD  = 6'd0;
    localparam logic [5:0] OP_ADDI = 6'd1;
    localparam logic [5:0] OP_SW   = 6'd7;
    localparam logic [5:0] OP_BNE  = 6'd8;

    logic             clk = 1'b0;
    logic             rst_n, allocValid, cdbValid, flush;
    logic [5:0]       allocType;
    logic [4:0]       allocDest;
    logic             allocReady;
    logic [TAG_W-1:0] allocTag, cdbTag;
    logic [31:0]      cdbData;
    logic             ROBwriteEnable, memCommit;
    logic [31:0]      ROBwriteData;
    logic [4:0]       ROBwriteIndex;
    logic [TAG_W:0]   count;
`ifdef ROB_FWD_EN
    logic [TAG_W-1:0] qryTag;
    logic             qryHit;
    logic [31:0]      qryData;
`endif

    reorder_buffer #(.TAG_W(TAG_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .allocValid(allocValid), .allocType(allocType), .allocDest(allocDest),
        .allocReady(allocReady), .allocTag(allocTag),
        .cdbValid(cdbValid), .cdbTag(cdbTag), .cdbData(cdbData),
        .flush(flush),
        .ROBwriteEnable(ROBwriteEnable), .ROBwriteData(ROBwriteData),
        .ROBwriteIndex(ROBwriteIndex), .memCommit(memCommit), .count(count)
`ifdef ROB_FWD_EN
        , .qryTag(qryTag), .qryHit(qryHit), .qryData(qryData)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: program-ordered list of in-flight instructions.
    typedef struct {
        int          tag;
        logic [5:0]  typ;
        logic [4:0]  dest;
        bit          rdy;
        logic [31:0] data;
    } ent_t;

    ent_t        mq[$];
    int          m_tail;
    bit          m_we, m_mem;
    logic [31:0] m_wd;
    logic [4:0]  m_wi;

    int pass_cnt = 0;
    int total_cnt = 0;

    function automatic bit writes_reg(logic [5:0] t);
        return (t <= 6'd9) && (t != OP_SW) && (t != OP_BNE);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic model_edge();
        ent_t e;
        bit   do_commit;
        if (!rst_n) begin
            mq.delete(); m_tail = 0; m_we = 0; m_mem = 0; m_wd = 0; m_wi = 0;
        end else if (flush) begin
            mq.delete(); m_tail = 0; m_we = 0; m_mem = 0;
        end else begin
            bit was_full = (mq.size() == DEPTH);
            do_commit = (mq.size() > 0) && mq[0].rdy && !m_we;
            if (do_commit) e = mq[0];
            if (cdbValid)
                foreach (mq[i])
                    if (mq[i].tag == int'(cdbTag)) begin
                        mq[i].rdy = 1; mq[i].data = cdbData;
                    end
            if (do_commit) begin
                void'(mq.pop_front());
                m_we  = writes_reg(e.typ);
                m_mem = (e.typ == OP_SW);
                if (m_we) begin m_wd = e.data; m_wi = e.dest; end
            end else begin
                m_we = 0; m_mem = 0;
            end
            if (allocValid && !was_full) begin
                ent_t n;
                n.tag = m_tail; n.typ = allocType; n.dest = allocDest; n.rdy = 0; n.data = 0;
                mq.push_back(n);
                m_tail = (m_tail + 1) % DEPTH;
            end
        end
    endtask

    // Apply one cycle of inputs, advance the model at the edge, compare just after it.
    task automatic step(input bit av, input logic [5:0] at, input logic [4:0] ad,
                        input bit cv, input int ct, input logic [31:0] cd,
                        input bit fl, input bit rn);
        allocValid = av; allocType = at; allocDest = ad;
        cdbValid = cv; cdbTag = ct[TAG_W-1:0]; cdbData = cd;
        flush = fl; rst_n = rn;
        @(posedge clk);
        model_edge();
        #1;
        check("count", 32'(count), 32'(mq.size()));
        check("allocReady", 32'(allocReady), 32'(mq.size() != DEPTH));
        check("allocTag", 32'(allocTag), 32'(m_tail));
        check("ROBwriteEnable", 32'(ROBwriteEnable), 32'(m_we));
        check("memCommit", 32'(memCommit), 32'(m_mem));
        check("ROBwriteData", ROBwriteData, m_wd);
        check("ROBwriteIndex", 32'(ROBwriteIndex), 32'(m_wi));
`ifdef ROB_FWD_EN
        begin
            bit hit = 0; logic [31:0] d = 0;
            foreach (mq[i]) if (mq[i].tag == int'(qryTag) && mq[i].rdy) begin hit = 1; d = mq[i].data; end
            check("qryHit", 32'(qryHit), 32'(hit));
            if (hit) check("qryData", qryData, d);
        end
`endif
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 1);
    endtask

    initial begin
        int we_seen, mem_pulses;
        logic [31:0] we_pat, idx_pat;
        m_tail = 0; m_we = 0; m_mem = 0; m_wd = 0; m_wi = 0;
`ifdef ROB_FWD_EN
        qryTag = '0;
`endif
        step(0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        // Reset values, pinned by literals
        check("rst_we", 32'(ROBwriteEnable), 0);
        check("rst_wd", ROBwriteData, 0);
        check("rst_wi", 32'(ROBwriteIndex), 0);
        check("rst_mem", 32'(memCommit), 0);
        check("rst_ready", 32'(allocReady), 1);
        check("rst_tag", 32'(allocTag), 0);
        check("rst_count", 32'(count), 0);

        // Single add, completed, then retired one cycle after the CDB edge
        step(1, OP_ADD, 5, 0, 0, 0, 0, 1);
        check("add_count", 32'(count), 1);
        step(0, 0, 0, 1, 0, 32'h2A, 0, 1);
        check("add_we_not_yet", 32'(ROBwriteEnable), 0);
        step(0, 0, 0, 0, 0, 0, 0, 1);
        check("add_we", 32'(ROBwriteEnable), 1);
        check("add_idx", 32'(ROBwriteIndex), 5);
        check("add_data", ROBwriteData, 32'h2A);
        step(0, 0, 0, 0, 0, 0, 0, 1);
        check("add_we_width", 32'(ROBwriteEnable), 0);
        check("add_hold_data", ROBwriteData, 32'h2A);
        check("add_count0", 32'(count), 0);

        // Fill to capacity; the ninth request is refused and tail has wrapped
        step(0, 0, 0, 0, 0, 0, 1, 1);
        for (int i = 0; i < DEPTH; i++) step(1, OP_ADDI, 5'(i), 0, 0, 0, 0, 1);
        check("full_ready", 32'(allocReady), 0);
        check("full_count", 32'(count), 8);
        check("full_tag_wrap", 32'(allocTag), 0);
        step(1, OP_ADDI, 9, 0, 0, 0, 0, 1);
        check("ninth_count", 32'(count), 8);

        // Three addi entries completed out of order; strobes every other cycle in order
        step(0, 0, 0, 0, 0, 0, 1, 1);
        for (int i = 1; i <= 3; i++) step(1, OP_ADDI, 5'(i), 0, 0, 0, 0, 1);
        step(0, 0, 0, 1, 2, 32'h300, 0, 1);
        step(0, 0, 0, 1, 1, 32'h200, 0, 1);
        step(0, 0, 0, 1, 0, 32'h100, 0, 1);
        we_pat = 0; idx_pat = 0;
        for (int i = 0; i < 6; i++) begin
            step(0, 0, 0, 0, 0, 0, 0, 1);
            we_pat[i] = ROBwriteEnable;
            idx_pat[i*5 +: 5] = ROBwriteIndex;
        end
        check("seq_we_pattern", we_pat, 32'b010101);
        check("seq_idx_order", idx_pat, {2'b0, 5'd3, 5'd3, 5'd2, 5'd2, 5'd1, 5'd1});

        // Store then branch: one memory pulse, no register strobe
        step(0, 0, 0, 0, 0, 0, 1, 1);
        step(1, OP_SW, 0, 0, 0, 0, 0, 1);
        step(1, OP_BNE, 0, 0, 0, 0, 0, 1);
        we_seen = 0; mem_pulses = 0;
        step(0, 0, 0, 1, 0, 32'h11, 0, 1);
        we_seen += ROBwriteEnable; mem_pulses += memCommit;
        step(0, 0, 0, 1, 1, 32'h22, 0, 1);
        we_seen += ROBwriteEnable; mem_pulses += memCommit;
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, 0, 0, 0, 0, 1);
            we_seen += ROBwriteEnable; mem_pulses += memCommit;
        end
        check("swbne_mem_pulses", mem_pulses, 1);
        check("swbne_no_we", we_seen, 0);
        check("swbne_count", 32'(count), 0);

        // Flush with simultaneous allocation wins; nothing retires afterwards
        for (int i = 0; i < 4; i++) step(1, OP_ADD, 5'(10 + i), 0, 0, 0, 0, 1);
        step(0, 0, 0, 1, 0, 32'h55, 0, 1);
        step(1, OP_ADD, 20, 0, 0, 0, 1, 1);
        check("flush_count", 32'(count), 0);
        check("flush_tag", 32'(allocTag), 0);
        we_seen = 0;
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, 1, i, 32'h77, 0, 1);
            we_seen += ROBwriteEnable;
        end
        check("flush_no_we", we_seen, 0);

        // Randomised traffic against the model
        for (int c = 0; c < 3000; c++) begin
            bit fl = ($urandom_range(0, 99) < 3);
            bit rn = ($urandom_range(0, 199) != 0);
`ifdef ROB_FWD_EN
            qryTag = TAG_W'($urandom_range(0, DEPTH - 1));
`endif
            step($urandom_range(0, 99) < 55, 6'($urandom_range(0, 9)), 5'($urandom),
                 $urandom_range(0, 99) < 50, $urandom_range(0, DEPTH - 1), $urandom,
                 fl, rn);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
